gaussian_window_gen: RTL
========================

// Module: gaussian_window_gen
// PURPOSE
//   Streaming 7x7 window generator that feeds the Gaussian blur datapath. It accepts a
//   raster-order 8-bit pixel stream, one pixel per handshake, and buffers WIDTH-1 image
//   rows in line buffers. It emits each complete WIDTH x WIDTH neighbourhood as one
//   flattened 392-bit word, already packed in the layout the blur core's input_pixels
//   port expects. Only interior windows (fully inside the image) are produced.
// PARAMETERS
//   BITS   8   pixel width in bits
//   WIDTH  7   window edge (odd, >=3); window bus width = BITS*WIDTH*WIDTH
//   IMG_W  64  image width in pixels (>= WIDTH)
//   IMG_H  64  image height in pixels (>= WIDTH)
// PORTS
//   clk          in   1                  single clock, all logic on rising edge
//   rst          in   1                  synchronous reset, active-high
//   pix_in       in   BITS               input pixel, raster order
//   pix_valid    in   1                  pix_in is valid
//   pix_ready    out  1                  block can accept pix_in this cycle
//   win_out      out  BITS*WIDTH*WIDTH   flattened window
//   win_valid    out  1                  win_out/win_col/win_row are valid
//   win_ready    in   1                  downstream accepts the window
//   win_col      out  16                 image column of the window centre
//   win_row      out  16                 image row of the window centre
//   frame_done   out  1                  1-cycle pulse when the last pixel of a frame is accepted
// BEHAVIOUR
//   - Reset (synchronous on rst=1): col/row counters=0, win_valid=0, frame_done=0,
//     win_out=0, win_col=0, win_row=0. pix_ready=1 in the cycle after reset.
//     Line-buffer RAM is not cleared. rst takes priority over every other event.
//   - Accept: a pixel is accepted when pix_valid && pix_ready.
//     pix_ready = !win_valid || win_ready (single-entry output register, no bubble).
//   - Position counters (c,r) give the accepted pixel's location. c increments per
//     accept; at c=IMG_W-1, c wraps to 0 and r increments. At (IMG_W-1, IMG_H-1),
//     both wrap to 0 and frame_done pulses in the next cycle.
//   - Line buffers: WIDTH-1 circular rows of IMG_W entries, addressed by c. On accept,
//     lb[k][c] <= lb[k+1][c] for k<WIDTH-2, and lb[WIDTH-2][c] <= pix_in. This is a
//     read-before-write of the same address in the same cycle.
//   - Window register W[i][j]: on accept, every row shifts one column left (j-1 <- j).
//     The new column j=WIDTH-1 is loaded with W[i] <= lb[i][c] for i<WIDTH-1, and
//     W[WIDTH-1] <= pix_in. Row 0 is the oldest image row; column 0 is the leftmost pixel.
//   - Emit: if the accepted pixel has r>=WIDTH-1 and c>=WIDTH-1, then on the next edge:
//     win_valid<=1, win_out<=packed W including this pixel, win_col<=c-WIDTH/2,
//     win_row<=r-WIDTH/2. Latency is 1 cycle from accept to win_valid.
//   - Packing: W[0][0] occupies the MSBs [BITS*WIDTH*WIDTH-1 -: BITS], with row-major
//     order after that; W[WIDTH-1][WIDTH-1] occupies [BITS-1:0].
//   - win_valid stays high, with win_out stable, until win_ready=1. It clears on the
//     handshake edge unless a new window is produced on the same edge; simultaneous
//     consume+produce keeps win_valid=1 and loads the new data.
//   - Windows per frame = (IMG_W-WIDTH+1)*(IMG_H-WIDTH+1). No output for border pixels.
//     Counter reset guarantees no cross-row or cross-frame mixing in emitted windows.
//   - No pixels are dropped: upstream must hold pix_in while pix_ready=0.
//   - Reset mid-frame: the partial frame is abandoned, any pending window is discarded,
//     and the next accepted pixel is treated as (0,0) of a new frame.
// TESTING  (IMG_W=IMG_H=8, WIDTH=7, pixel value = r*8+c, win_ready=1 unless stated)
//   1 Stream one frame -> exactly 4 windows, centres (3,3),(4,3),(3,4),(4,4) in row-major
//     order; first win_out MSB byte=0x00, LSB byte=54, W[3][3]=27.
//   2 Window 2 contents -> W[i][j]=i*8+j+1 for all i,j; frame_done is 1 cycle high after
//     pixel 63, and only then.
//   3 Hold win_ready=0 for 5 cycles at first window -> pix_ready=0, win_out stable,
//     no pixel lost; remaining windows match case 1.
//   4 Random pix_valid gaps (50%) -> window sequence identical to case 1.
//   5 Two back-to-back frames, second with value=255-(r*8+c) -> second frame first
//     window LSB byte=201, MSB byte=255, with no first-frame data.
//   6 Assert rst after 30 pixels, then stream a full frame -> win_valid=0 during reset;
//     output is exactly the 4 windows of case 1.

Source files
------------

// File: rtl/gaussian_window_gen_if.sv
// gaussian_window_gen_if: pixel-in / window-out stream bundle for the window generator
interface gaussian_window_gen_if #(
  parameter int BITS = 8,
  parameter int WIDTH = 7
);
  logic [BITS-1:0] pix_in;
  logic pix_valid;
  logic pix_ready;
  logic [BITS*WIDTH*WIDTH-1:0] win_out;
  logic win_valid;
  logic win_ready;
  logic [15:0] win_col;
  logic [15:0] win_row;
  logic frame_done;
  modport master (
    output pix_in, pix_valid, win_ready,
    input pix_ready, win_out, win_valid, win_col, win_row, frame_done
  );
  modport slave (
    input pix_in, pix_valid, win_ready,
    output pix_ready, win_out, win_valid, win_col, win_row, frame_done
  );
endinterface

// File: rtl/gaussian_window_gen.sv
// gaussian_window_gen: streaming WIDTH x WIDTH interior-window generator built on line buffers
module gaussian_window_gen #(
  parameter int BITS = 8,
  parameter int WIDTH = 7,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic clk,
  input logic rst,
  gaussian_window_gen_if.slave bus
);
  localparam int N = BITS*WIDTH*WIDTH;
  localparam int AW = $clog2(IMG_W);
  localparam logic [15:0] C_LAST = 16'(IMG_W-1);
  localparam logic [15:0] R_LAST = 16'(IMG_H-1);
  localparam logic [15:0] EDGE = 16'(WIDTH-1);
  localparam logic [15:0] HALF = 16'(WIDTH/2);
  logic [BITS-1:0] lb [WIDTH-1][IMG_W];
  logic [BITS-1:0] w [WIDTH][WIDTH];
  logic [BITS-1:0] wn [WIDTH][WIDTH];
  logic [N-1:0] packed_w;
  logic [15:0] c, r;
  logic [AW-1:0] a;
  logic accept, emit;
  assign bus.pix_ready = !bus.win_valid || bus.win_ready;
  assign accept = bus.pix_valid && bus.pix_ready;
  assign emit = accept && r >= EDGE && c >= EDGE;
  assign a = c[AW-1:0];
  // next window: every row shifts left, right column comes from the line buffers and the new pixel
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH-1; j++)
        wn[i][j] = w[i][j+1];
    for (int i = 0; i < WIDTH-1; i++)
      wn[i][WIDTH-1] = lb[i][a];
    wn[WIDTH-1][WIDTH-1] = bus.pix_in;
  end
  // flatten row-major with W[0][0] in the MSBs
  always_comb begin
    packed_w = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        packed_w[N-1-BITS*(i*WIDTH+j) -: BITS] = wn[i][j];
  end
  // line buffers rotate one row up at the current column; window register takes the shifted view
  always_ff @(posedge clk)
    if (accept) begin
      for (int k = 0; k < WIDTH-2; k++)
        lb[k][a] <= lb[k+1][a];
      lb[WIDTH-2][a] <= bus.pix_in;
      w <= wn;
    end
  // position counters, single-entry output register and end-of-frame pulse
  always_ff @(posedge clk)
    if (rst) begin
      c <= '0;
      r <= '0;
      bus.win_valid <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.win_out <= '0;
      bus.win_col <= '0;
      bus.win_row <= '0;
    end else begin
      bus.frame_done <= accept && c == C_LAST && r == R_LAST;
      if (accept) begin
        c <= c == C_LAST ? '0 : c + 16'd1;
        r <= c != C_LAST ? r : r == R_LAST ? '0 : r + 16'd1;
      end
      if (emit) begin
        bus.win_valid <= 1'b1;
        bus.win_out <= packed_w;
        bus.win_col <= c - HALF;
        bus.win_row <= r - HALF;
      end else if (bus.win_ready)
        bus.win_valid <= 1'b0;
    end
endmodule
